penalty_round_ctl: RTL
======================

Name: penalty_round_ctl

Overview:
- Match sequencer for the penalty shootout.
- Alternates kicks between player and CPU, times each aiming phase and decides goal or save from latched shot and keeper x-positions.
- Keeps per-side scores, applies early termination and sudden death, and declares the winner.
- Sits between the mouse controller outputs (xpos, left click) and the game-state/screen-selection logic; drives round/score/phase information to the drawing modules.

Parameters:
- N_ROUNDS, 5, regulation kicks per side (1..7).
- AIM_CYCLES, 65_000_000, clock cycles allowed in aiming phase before timeout.
- SHOW_CYCLES, 97_500_000, clock cycles the kick result is displayed.
- SAVE_RADIUS, 64, pixel distance below which the keeper saves.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- left_clicked  in  1  mouse left-button level; synchronous to clk
- ball_x  in  12  current shot aim x position (pixels)
- keeper_x  in  12  current keeper x position (pixels)
- phase  out  3  0 IDLE, 1 AIM, 2 RESOLVE, 3 SHOW, 4 OVER
- player_shooting  out  1  1 = player kicks this turn, 0 = CPU kicks
- kick_idx  out  4  kicks taken by current shooter, 0-based
- score_player  out  4  player goals
- score_cpu  out  4  CPU goals
- last_goal  out  1  result of most recent kick, valid in SHOW
- sudden_death  out  1  regulation exhausted with scores level
- match_over  out  1  high in OVER
- winner  out  2  0 none, 1 player, 2 CPU; valid in OVER

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; phase=IDLE.
  - Counters and edge-detect register cleared.
  - player_shooting resets to 1.
- Click edge: click = left_clicked & ~left_clicked_q, with a 1-cycle registered delay. A held button produces exactly one event.
- IDLE:
  - On click: clear scores, kick counters, sudden_death and winner; set player_shooting=1.
  - Go to AIM on the next cycle.
- AIM:
  - Timer counts 0..AIM_CYCLES-1.
  - On click: latch ball_x and keeper_x; go to RESOLVE.
  - On timer reaching AIM_CYCLES-1 without a click: timeout, go to RESOLVE.
    - If player is shooting, timeout is a miss.
    - If player is keeping, timeout is a goal.
  - Click in the same cycle as timeout: the click wins.
- RESOLVE (exactly 1 cycle):
  - goal = timeout rule, else (|ball_x - keeper_x| >= SAVE_RADIUS).
  - Difference is unsigned 12-bit absolute value computed without wrap: larger minus smaller.
  - last_goal <= goal; shooter's score increments, saturating at 15.
  - Shooter's kick count increments, saturating at 15.
  - Go to SHOW.
- SHOW:
  - Hold all outputs for SHOW_CYCLES cycles, then evaluate the end of match:
    - Regulation (both kick counts <= N_ROUNDS):
      - remP = N_ROUNDS - kicksP and remC = N_ROUNDS - kicksC.
      - End if score_player > score_cpu + remC, or score_cpu > score_player + remP.
    - After both sides take N_ROUNDS kicks:
      - End if scores differ.
      - Otherwise set sudden_death=1 and continue.
    - In sudden death: evaluate only after the CPU kick (equal kick counts); end if scores differ.
  - If end: go to OVER; winner = larger score.
  - Else: toggle player_shooting and go to AIM; timer cleared.
  - kick_idx shows the kick count of the new shooter.
- OVER: match_over=1; on click go to IDLE; outputs hold until then.
- Clicks in RESOLVE and SHOW are ignored; they are not queued.
- Reset mid-match returns to IDLE immediately with all state cleared.

Test Plan (AIM_CYCLES=100, SHOW_CYCLES=10, N_ROUNDS=5, SAVE_RADIUS=64):
- Reset, one click, then click in AIM with ball_x=300, keeper_x=100 -> RESOLVE 1 cycle later; last_goal=1, score_player=1; after 10 cycles phase=AIM, player_shooting=0.
- Player keeping, click with ball_x=200, keeper_x=250 (|diff|=50) -> save, score_cpu unchanged; diff exactly 64 -> goal.
- No click for 100 cycles: player shooting -> miss (last_goal=0); player keeping -> CPU goal.
- Player scores 3/3 and CPU misses 3/3 -> after CPU's 3rd kick, SHOW ends in OVER, winner=1, kick_idx=3.
- Regulation ends 4-4 -> sudden_death=1. Sudden-death pair goal/miss -> OVER, winner=1. Pair goal/goal -> continue.
- Hold left_clicked high 50 cycles in AIM -> exactly one kick resolved.
- Assert rst=0 in SHOW -> all outputs 0 asynchronously; phase=IDLE.

Source files
------------

// File: rtl/penalty_round_ctl.sv
// Penalty shootout match sequencer: alternates kicks, times aiming, resolves goal/save, scores, ends match.
// Latency: click edge acts one cycle after the button rises; RESOLVE is one cycle; SHOW holds SHOW_CYCLES.
// Backpressure: none; clicks outside IDLE/AIM/OVER are dropped, not queued.
module penalty_round_ctl #(
    parameter int N_ROUNDS    = 5,
    parameter int AIM_CYCLES  = 65_000_000,
    parameter int SHOW_CYCLES = 97_500_000,
    parameter int SAVE_RADIUS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        left_clicked,
    input  logic [11:0] ball_x,
    input  logic [11:0] keeper_x,
    output logic [2:0]  phase,
    output logic        player_shooting,
    output logic [3:0]  kick_idx,
    output logic [3:0]  score_player,
    output logic [3:0]  score_cpu,
    output logic        last_goal,
    output logic        sudden_death,
    output logic        match_over,
    output logic [1:0]  winner
);

    localparam int TMAX = (AIM_CYCLES > SHOW_CYCLES) ? AIM_CYCLES : SHOW_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] AIM_LAST  = TW'(AIM_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [4:0]    NR        = 5'(N_ROUNDS);
    localparam logic [11:0]   RADIUS    = 12'(SAVE_RADIUS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AIM     = 3'd1,
        S_RESOLVE = 3'd2,
        S_SHOW    = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          left_q;
    logic          click_q;
    logic [TW-1:0] timer;
    logic [11:0]   shot_x;
    logic [11:0]   keep_x;
    logic          timed_out;
    logic [3:0]    kicks_p;
    logic [3:0]    kicks_c;

    logic          start_match;
    logic          aim_take;
    logic          aim_timeout;
    logic          resolve;
    logic          show_done;

    logic [11:0]   abs_diff;
    logic          kick_goal;
    logic [4:0]    rem_p;
    logic [4:0]    rem_c;
    logic          in_regulation;
    logic          match_end;
    logic          enter_sd;

    // Registered rising-edge detect: a held button yields a single one-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q  <= 1'b0;
            click_q <= 1'b0;
        end else begin
            left_q  <= left_clicked;
            click_q <= left_clicked & ~left_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_match = 1'b0;
        aim_take    = 1'b0;
        aim_timeout = 1'b0;
        resolve     = 1'b0;
        show_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (click_q) begin
                    start_match = 1'b1;
                    state_nxt   = S_AIM;
                end
            end
            S_AIM: begin
                if (click_q) begin
                    aim_take  = 1'b1;
                    state_nxt = S_RESOLVE;
                end else if (timer == AIM_LAST) begin
                    aim_timeout = 1'b1;
                    state_nxt   = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                resolve   = 1'b1;
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (timer == SHOW_LAST) begin
                    show_done = 1'b1;
                    state_nxt = match_end ? S_OVER : S_AIM;
                end
            end
            S_OVER: begin
                if (click_q) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One timer serves both AIM and SHOW; it restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (state == S_AIM || state == S_SHOW) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shot_x    <= '0;
            keep_x    <= '0;
            timed_out <= 1'b0;
        end else if (aim_take) begin
            shot_x    <= ball_x;
            keep_x    <= keeper_x;
            timed_out <= 1'b0;
        end else if (aim_timeout) begin
            timed_out <= 1'b1;
        end
    end

    always_comb begin
        abs_diff  = (shot_x >= keep_x) ? (shot_x - keep_x) : (keep_x - shot_x);
        // An unused aiming window favours the keeper side when the player shoots, the CPU otherwise.
        kick_goal = timed_out ? ~player_shooting : (abs_diff >= RADIUS);
    end

    always_comb begin
        rem_p         = NR - {1'b0, kicks_p};
        rem_c         = NR - {1'b0, kicks_c};
        in_regulation = ({1'b0, kicks_p} <= NR) && ({1'b0, kicks_c} <= NR);
        match_end     = 1'b0;
        enter_sd      = 1'b0;
        if (in_regulation) begin
            match_end = ({1'b0, score_player} > ({1'b0, score_cpu} + rem_c)) ||
                        ({1'b0, score_cpu} > ({1'b0, score_player} + rem_p));
            enter_sd  = !match_end && ({1'b0, kicks_p} == NR) && ({1'b0, kicks_c} == NR);
        end else begin
            // Sudden death is only decided once both sides have kicked the same number of times.
            match_end = (kicks_p == kicks_c) && (score_player != score_cpu);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_shooting <= 1'b1;
            kicks_p         <= '0;
            kicks_c         <= '0;
            score_player    <= '0;
            score_cpu       <= '0;
            last_goal       <= 1'b0;
            sudden_death    <= 1'b0;
            winner          <= '0;
        end else begin
            if (start_match) begin
                player_shooting <= 1'b1;
                kicks_p         <= '0;
                kicks_c         <= '0;
                score_player    <= '0;
                score_cpu       <= '0;
                sudden_death    <= 1'b0;
                winner          <= '0;
            end
            if (resolve) begin
                last_goal <= kick_goal;
                if (player_shooting) begin
                    kicks_p <= (kicks_p == 4'hF) ? kicks_p : kicks_p + 4'd1;
                    if (kick_goal && score_player != 4'hF) begin
                        score_player <= score_player + 4'd1;
                    end
                end else begin
                    kicks_c <= (kicks_c == 4'hF) ? kicks_c : kicks_c + 4'd1;
                    if (kick_goal && score_cpu != 4'hF) begin
                        score_cpu <= score_cpu + 4'd1;
                    end
                end
            end
            if (show_done) begin
                if (match_end) begin
                    winner <= (score_player > score_cpu) ? 2'd1 : 2'd2;
                end else begin
                    player_shooting <= ~player_shooting;
                    if (enter_sd) begin
                        sudden_death <= 1'b1;
                    end
                end
            end
        end
    end

    assign phase      = state;
    assign match_over = (state == S_OVER);
    assign kick_idx   = player_shooting ? kicks_p : kicks_c;

endmodule
